// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller:
// decode table, segment bit positions, FSM state and digit register layout.
package seg_pkg;

  // Segment bit positions on the seg output (active-high).
  localparam int SEG_DP = 0;
  localparam int SEG_A  = 1;
  localparam int SEG_B  = 2;
  localparam int SEG_C  = 3;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 5;
  localparam int SEG_F  = 6;
  localparam int SEG_G  = 7;

  // Hex digit -> {g,f,e,d,c,b,a}; lands on seg[7:1].
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_DRIVE = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

endpackage

// File: rtl/seg_decode.sv
// Combinational hex to seven-segment decoder driven by the shared table.
module seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] segs
);

  assign segs = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed common-anode seven-segment scan controller with a blanking cycle
// between digits. Optional per-digit blinking is built when SEG_BLINK_EN is defined.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV    = 10000,
  parameter int NUM_DIGITS = 8
`ifdef SEG_BLINK_EN
  , parameter int BLINK_DIV = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_addr,
  input  logic [4:0]            wr_data,
  input  logic [NUM_DIGITS-1:0] en_mask,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0] blink_mask,
`endif
  output logic [7:0]            seg,
  output logic [7:0]            ds,
  output state_t                state_dbg
);

  // Write port: a transfer happens on any edge where wr_valid && wr_ready;
  // wr_ready is high in every state except RESET and does not depend on wr_valid.

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  state_t        state;
  logic          rst_done;
  logic [DW-1:0] div_cnt;
  logic [2:0]    idx;
  digit_t        regs [8];

  logic [7:0]    en_full;
  logic          tick;
  logic          wr_fire;
  logic          wr_hit;
  logic [2:0]    idx_wrap;
  digit_t        cur;
  logic [6:0]    dec_segs;
  logic          blink_off;
  logic          lit;

  assign en_full   = 8'(en_mask);
  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  assign wr_ready  = (state != ST_RESET);
  assign wr_fire   = wr_valid & wr_ready;
  assign wr_hit    = wr_fire && ({29'd0, wr_addr} < 32'(NUM_DIGITS));
  assign idx_wrap  = (idx == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx + 3'd1;
  assign cur       = regs[idx];
  assign lit       = en_full[idx] & ~blink_off;
  assign state_dbg = state;

  seg_decode u_decode (
    .hex  (cur.hex),
    .segs (dec_segs)
  );

`ifdef SEG_BLINK_EN
  logic [7:0]  blink_full;
  logic        blink_phase;
  logic [15:0] frame_cnt;

  assign blink_full = 8'(blink_mask);
  assign blink_off  = blink_phase & blink_full[idx];

  // A frame ends on the tick of the last digit's slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (state == ST_DRIVE && tick && idx == 3'(NUM_DIGITS - 1)) begin
      if (frame_cnt == 16'(BLINK_DIV - 1)) begin
        frame_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end
`else
  assign blink_off = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RESET;
      rst_done <= 1'b0;
      div_cnt  <= '0;
      idx      <= 3'd0;
      ds       <= 8'hFF;
      seg      <= 8'h00;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (wr_hit) regs[wr_addr] <= digit_t'(wr_data);

      case (state)
        // Held for one extra cycle after rst falls before the first slot.
        ST_RESET: begin
          rst_done <= 1'b1;
          if (rst_done) begin
            state <= ST_DRIVE;
            ds    <= lit ? ~(8'd1 << idx) : 8'hFF;
            seg   <= lit ? {dec_segs, cur.dp} : 8'h00;
          end
        end
        // Prescaler restarts at every slot so DRIVE lasts exactly CLK_DIV cycles.
        ST_DRIVE: begin
          if (tick) begin
            state   <= ST_BLANK;
            div_cnt <= '0;
            idx     <= idx_wrap;
            ds      <= 8'hFF;
            seg     <= 8'h00;
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        // Outputs are latched here and held for the whole slot.
        ST_BLANK: begin
          state <= ST_DRIVE;
          ds    <= lit ? ~(8'd1 << idx) : 8'hFF;
          seg   <= lit ? {dec_segs, cur.dp} : 8'h00;
        end
        default: state <= ST_RESET;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with CLK_DIV=4: an 8-digit instance and a
// 4-digit instance for out-of-range addressing.
module tb_seg_scan_ctrl;
  import seg_pkg::*;

  logic       clk;
  logic       rst;
  logic       wr_valid, wr_ready;
  logic [2:0] wr_addr;
  logic [4:0] wr_data;
  logic [7:0] en_mask;
  logic [7:0] seg, ds;
  state_t     state_dbg;

  logic       w4_valid, w4_ready;
  logic [2:0] w4_addr;
  logic [4:0] w4_data;
  logic [3:0] en_mask4;
  logic [7:0] seg4, ds4;
  state_t     state_dbg4;

`ifdef SEG_BLINK_EN
  logic [7:0] blink_mask;
  logic [3:0] blink_mask4;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .CLK_DIV    (4),
    .NUM_DIGITS (8)
`ifdef SEG_BLINK_EN
    , .BLINK_DIV (1)
`endif
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .en_mask   (en_mask),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .seg       (seg),
    .ds        (ds),
    .state_dbg (state_dbg)
  );

  seg_scan_ctrl #(
    .CLK_DIV    (4),
    .NUM_DIGITS (4)
`ifdef SEG_BLINK_EN
    , .BLINK_DIV (1)
`endif
  ) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .wr_valid  (w4_valid),
    .wr_ready  (w4_ready),
    .wr_addr   (w4_addr),
    .wr_data   (w4_data),
    .en_mask   (en_mask4),
`ifdef SEG_BLINK_EN
    .blink_mask(blink_mask4),
`endif
    .seg       (seg4),
    .ds        (ds4),
    .state_dbg (state_dbg4)
  );

  // Driver tasks
  task automatic go_to(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] exp_ds, input logic [7:0] exp_seg);
    check({tag, ".ds"}, ds, exp_ds);
    check({tag, ".seg"}, seg, exp_seg);
  endtask

  task automatic check_out4(input string tag, input logic [7:0] exp_ds, input logic [7:0] exp_seg);
    check({tag, ".ds4"}, ds4, exp_ds);
    check({tag, ".seg4"}, seg4, exp_seg);
  endtask

  // cyc counts falling edges after the first reset release; slot k of frame f
  // on the 8-digit instance is visible from cyc 2+5k+40f for 4 cycles.
  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = 3'd0;
    wr_data  = 5'd0;
    en_mask  = 8'hFF;
    w4_valid = 1'b0;
    w4_addr  = 3'd0;
    w4_data  = 5'd0;
    en_mask4 = 4'hF;
`ifdef SEG_BLINK_EN
    blink_mask  = 8'h00;
    blink_mask4 = 4'h0;
`endif

    repeat (3) @(negedge clk);
    check_out("reset", 8'hFF, 8'h00);
    check("reset.wr_ready", 8'(wr_ready), 8'h00);
    check("reset.state", 8'(state_dbg), 8'(ST_RESET));
    rst = 1'b0;

    go_to(1);
    check("release1.wr_ready", 8'(wr_ready), 8'h00);
    check_out("release1", 8'hFF, 8'h00);

    go_to(2);
    check_out("first_drive", 8'hFE, 8'h7E);
    check("first_drive.wr_ready", 8'(wr_ready), 8'h01);
    check_out4("first_drive", 8'hFE, 8'h7E);
    wr_valid = 1'b1; wr_addr = 3'd1; wr_data = 5'h13;

    go_to(3);
    wr_valid = 1'b0;
    check("oor.wr4_ready", 8'(w4_ready), 8'h01);
    w4_valid = 1'b1; w4_addr = 3'd6; w4_data = 5'h18;

    go_to(4);
    w4_addr = 3'd3; w4_data = 5'h01;

    go_to(5);
    w4_valid = 1'b0;

    go_to(6);
    check_out("blank0", 8'hFF, 8'h00);
    go_to(7);
    check_out("slot1_start", 8'hFD, 8'h9F);
    go_to(10);
    check_out("slot1_end", 8'hFD, 8'h9F);
    go_to(11);
    check_out("blank1", 8'hFF, 8'h00);
    go_to(12);
    check_out("slot2", 8'hFB, 8'h7E);

    go_to(22);
    check_out4("oor_slot0", 8'hFE, 8'h7E);
    go_to(27);
    check_out4("oor_slot1", 8'hFD, 8'h7E);
    go_to(32);
    check_out4("oor_slot2", 8'hFB, 8'h7E);
    go_to(37);
    check_out4("oor_slot3", 8'hF7, 8'h0C);

    go_to(42);
    check_out("f1_slot0", 8'hFE, 8'h7E);
    go_to(43);
    check("midslot_a.seg", seg, 8'h7E);
    wr_valid = 1'b1; wr_addr = 3'd0; wr_data = 5'h08;
    go_to(44);
    check("midslot_b.seg", seg, 8'h7E);
    wr_addr = 3'd2; wr_data = 5'h05;
    go_to(45);
    check_out("midslot_c", 8'hFE, 8'h7E);
    wr_data = 5'h0A;
    go_to(46);
    wr_valid = 1'b0;
    check_out("f1_blank0", 8'hFF, 8'h00);

    go_to(52);
    check_out("last_wins_slot2", 8'hFB, 8'hEE);
    go_to(82);
    check_out("f2_slot0_new", 8'hFE, 8'hFE);

    go_to(86);
    check_out("f2_blank0", 8'hFF, 8'h00);
    en_mask = 8'h7F;
    go_to(87);
    check_out("f2_slot1", 8'hFD, 8'h9F);
    go_to(112);
    check_out("f2_slot6", 8'hBF, 8'h7E);
    go_to(117);
    check_out("masked_slot7", 8'hFF, 8'h00);
    go_to(120);
    check_out("masked_slot7_end", 8'hFF, 8'h00);
    go_to(121);
    check_out("wrap_blank", 8'hFF, 8'h00);
    go_to(122);
    check_out("wrap_slot0", 8'hFE, 8'hFE);

    go_to(124);
    rst = 1'b1;
    go_to(125);
    check_out("midscan_reset", 8'hFF, 8'h00);
    check("midscan_reset.wr_ready", 8'(wr_ready), 8'h00);
    rst = 1'b0;
    go_to(126);
    check("rerelease1.wr_ready", 8'(wr_ready), 8'h00);
    check_out("rerelease1", 8'hFF, 8'h00);
    go_to(127);
    check_out("rerelease_slot0", 8'hFE, 8'h7E);
    check("rerelease.wr_ready", 8'(wr_ready), 8'h01);

`ifdef SEG_BLINK_EN
    blink_mask = 8'h01;
    go_to(167);
    check_out("blink_f1_slot0", 8'hFF, 8'h00);
    go_to(172);
    check_out("blink_f1_slot1", 8'hFD, 8'h7E);
    go_to(207);
    check_out("blink_f2_slot0", 8'hFE, 8'h7E);
    go_to(247);
    check_out("blink_f3_slot0", 8'hFF, 8'h00);
`endif

    go_to(cyc + 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
